// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 registered channel multiplexer family.
package mux_pkg;
    localparam logic MODE_EXT      = 1'b0;
    localparam logic MODE_RR       = 1'b1;
    localparam int   DEFAULT_DATA_W = 8;
    localparam int   CNT_W          = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, searching cyclically.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] idx
);
    int   c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N_CH; i++) begin
            // ptr is always < N_CH, so a single wrap subtraction suffices
            c = int'(ptr) + i;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            if (!found && req[c]) begin
                gnt[c] = 1'b1;
                idx    = c[SEL_W-1:0];
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_na1_rr.sv
// N-to-1 registered mux with valid/ready handshake, external or round-robin selection.
// Optional transfer counter output enabled by defining MUX_NA1_CNT_EN.
module mux_na1_rr
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         selector,
    input  logic [N_CH-1:0]          valid_in,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic [N_CH-1:0]          ready_in,
    input  logic                     ready_out,
    output logic                     valid_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         sel_out
`ifdef MUX_NA1_CNT_EN
    ,
    output logic [CNT_W-1:0]         xfer_count
`endif
);
    logic [DATA_W-1:0] ch_data [N_CH];
    logic [N_CH-1:0]   ext_gnt;
    logic [N_CH-1:0]   rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic [N_CH-1:0]   gnt;
    logic [SEL_W-1:0]  g_idx;
    logic              free;
    logic              xfer;

    logic              valid_out_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic [SEL_W-1:0]  sel_out_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  ptr_next;

    // Out-of-range selector values match no channel and therefore grant nothing
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ch_data[gi] = data_in[gi*DATA_W +: DATA_W];
        assign ext_gnt[gi] = valid_in[gi] && (selector == SEL_W'(gi));
    end

    rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
        .req (valid_in),
        .ptr (ptr_reg),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign free     = !valid_out_reg || ready_out;
    assign gnt      = (mode == MODE_RR) ? rr_gnt : ext_gnt;
    assign g_idx    = (mode == MODE_RR) ? rr_idx : selector;
    assign ready_in = (reset_L && free) ? gnt : '0;
    assign xfer     = |(ready_in & valid_in);
    assign ptr_next = (g_idx == SEL_W'(N_CH - 1)) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
            sel_out_reg   <= '0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            valid_out_reg <= 1'b1;
            data_out_reg  <= ch_data[g_idx];
            sel_out_reg   <= g_idx;
            if (mode == MODE_RR) begin
                ptr_reg <= ptr_next;
            end
        end else if (ready_out) begin
            valid_out_reg <= 1'b0;
        end
    end

    assign valid_out = valid_out_reg;
    assign data_out  = data_out_reg;
    assign sel_out   = sel_out_reg;

`ifdef MUX_NA1_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_reg <= '0;
        end else if (xfer && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign xfer_count = cnt_reg;
`endif
endmodule

// File: tb/tb_mux_na1_rr.sv
// Self-checking bench for mux_na1_rr (N_CH=4, DATA_W=8); counter checks when MUX_NA1_CNT_EN is defined.
module tb_mux_na1_rr;
    logic        clk;
    logic        reset_L;
    logic        mode;
    logic [1:0]  selector;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [3:0]  ready_in;
    logic        ready_out;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [1:0]  sel_out;
    logic [7:0]  ch [4];
`ifdef MUX_NA1_CNT_EN
    logic [15:0] xfer_count;
`endif

    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    bit       m_valid;
    logic [7:0] m_data;
    int       m_sel;
    int       m_ptr;
    int       m_cnt;

    assign data_in = {ch[3], ch[2], ch[1], ch[0]};

    mux_na1_rr #(.N_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .mode      (mode),
        .selector  (selector),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out)
`ifdef MUX_NA1_CNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (mode == 1'b0) begin
            if (int'(selector) < 4 && valid_in[selector]) return int'(selector);
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            if (valid_in[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        g = exp_grant();
        if (reset_L === 1'b1 && (!m_valid || ready_out) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 8'h00; m_sel = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // One clock edge; model follows the transfer rules, outputs settle #1 later
    task automatic tick();
        int g;
        bit fr;
        g  = exp_grant();
        fr = !m_valid || ready_out;
        @(posedge clk);
        if (reset_L) begin
            if (fr && g >= 0) begin
                m_valid = 1; m_data = ch[g]; m_sel = g;
                if (mode) m_ptr = (g + 1) % 4;
                if (m_cnt < 65535) m_cnt++;
            end else if (ready_out) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        mode = 1'b1; selector = 2'd0; valid_in = 4'b1111; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'h5A + 8'(c);
        tick();
        tick();
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_out); end
        n_vec++; if (sel_out !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d exp 0", sel_out); end
        n_vec++; if (ready_in !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp 0000", ready_in); end
        @(negedge clk);
        reset_L = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_ext_sel();
        do_reset();
        mode = 1'b0; selector = 2'd2; valid_in = 4'b0100; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'($urandom);
        ch[2] = 8'hA5;
        #1;
        n_vec++; if (ready_in !== 4'b0100 || ready_in !== exp_ready()) begin n_err++; $display("FAIL ext_ready got %b exp 0100", ready_in); end
        tick();
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL ext_valid got %b exp 1", valid_out); end
        n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL ext_data got %h exp a5", data_out); end
        n_vec++; if (sel_out !== 2'd2) begin n_err++; $display("FAIL ext_sel got %0d exp 2", sel_out); end
        $display("test_ext_sel done");
    endtask

    task automatic test_rr_all();
        logic [7:0] exp_d;
        do_reset();
        mode = 1'b1; valid_in = 4'b1111; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'h10 + 8'(c);
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++; if (ready_in !== exp_ready()) begin n_err++; $display("FAIL rr_all_ready[%0d] got %b exp %b", i, ready_in, exp_ready()); end
            tick();
            exp_d = 8'h10 + 8'(i % 4);
            n_vec++; if (data_out !== exp_d || valid_out !== 1'b1) begin n_err++; $display("FAIL rr_all_data[%0d] got %h/%b exp %h/1", i, data_out, valid_out, exp_d); end
        end
        $display("test_rr_all done");
    endtask

    task automatic test_rr_skip();
        int exp_s;
        do_reset();
        mode = 1'b1; valid_in = 4'b0001; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'hC0 + 8'(c);
        tick();
        valid_in = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            tick();
            exp_s = (i % 2 == 0) ? 3 : 0;
            n_vec++; if (sel_out !== 2'(exp_s) || sel_out !== 2'(m_sel)) begin n_err++; $display("FAIL rr_skip_sel[%0d] got %0d exp %0d", i, sel_out, exp_s); end
        end
        $display("test_rr_skip done");
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; selector = 2'd0; valid_in = 4'b0001; ready_out = 1'b1;
        ch[0] = 8'h3C;
        #1;
        tick();
        ch[0] = 8'h77;
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ready_in !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, ready_in); end
            tick();
            n_vec++; if (data_out !== 8'h3C || valid_out !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got %h/%b exp 3c/1", i, data_out, valid_out); end
        end
        valid_in = 4'b0000; ready_out = 1'b1;
        #1;
        tick();
        n_vec++; if (valid_out !== 1'b0 || data_out !== 8'h3C) begin n_err++; $display("FAIL bp_drain got %h/%b exp 3c/0", data_out, valid_out); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mode = 1'b1; valid_in = 4'b1111; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'hE0 + 8'(c);
        #1;
        tick();
        ready_out = 1'b0;
        #1;
        tick();
        #2;
        reset_L = 1'b0;
        model_reset();
        ready_out = 1'b1;
        #1;
        n_vec++; if (ready_in !== 4'b0000 || valid_out !== 1'b0) begin n_err++; $display("FAIL stall_reset got %b/%b exp 0000/0", ready_in, valid_out); end
        tick();
        n_vec++; if (ready_in !== 4'b0000 || valid_out !== 1'b0) begin n_err++; $display("FAIL stall_reset_hold got %b/%b exp 0000/0", ready_in, valid_out); end
        @(negedge clk);
        reset_L = 1'b1;
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            selector  = 2'($urandom);
            valid_in  = 4'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) ch[c] = 8'($urandom);
            #1;
            n_vec++; if (ready_in !== exp_ready()) begin n_err++; $display("FAIL rand_ready[%0d] got %b exp %b", i, ready_in, exp_ready()); end
            tick();
            n_vec++; if (valid_out !== m_valid || data_out !== m_data || sel_out !== 2'(m_sel)) begin
                n_err++;
                $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", i, valid_out, data_out, sel_out, m_valid, m_data, m_sel);
            end
`ifdef MUX_NA1_CNT_EN
            n_vec++; if (xfer_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, xfer_count, m_cnt); end
`endif
        end
        $display("test_random done");
    endtask

    task automatic test_count();
`ifdef MUX_NA1_CNT_EN
        do_reset();
        mode = 1'b1; valid_in = 4'b1111; ready_out = 1'b1;
        for (int c = 0; c < 4; c++) ch[c] = 8'(c);
        for (int i = 0; i < 1000; i++) tick();
        n_vec++; if (xfer_count !== 16'd1000) begin n_err++; $display("FAIL cnt_1000 got %0d exp 1000", xfer_count); end
        for (int i = 1000; i < 70000; i++) tick();
        n_vec++; if (xfer_count !== 16'hFFFF || xfer_count !== 16'(m_cnt)) begin n_err++; $display("FAIL cnt_sat got %h exp ffff", xfer_count); end
        $display("test_count done");
`else
        $display("test_count skipped (counter not built)");
`endif
    endtask

    initial begin
        reset_L = 1'b0; mode = 1'b0; selector = 2'd0; valid_in = 4'b0000; ready_out = 1'b0;
        for (int c = 0; c < 4; c++) ch[c] = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_L = 1'b1;
        test_reset();
        test_ext_sel();
        test_rr_all();
        test_rr_skip();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
        test_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux_na1_rr.md
# mux_na1_rr

Parametrised N-to-1 registered multiplexer with per-channel valid/ready handshake, output hold-last-value and selectable channel arbitration (external selector or internal round-robin). It generalises the team's 2-to-1, 2-bit valid-gated mux to N channels of W bits with a clocked output stage and backpressure. It sits between the per-lane FIFOs and the single-lane serialiser/downstream FIFO.

## Interface
Parameters:
- N_CH, 4, number of input channels (2..16)
- DATA_W, 8, data width per channel
- SEL_W, $clog2(N_CH), localparam, channel index width

Ports:
- clk  input  1  single clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- mode  input  1  0 = external selector, 1 = round-robin
- selector  input  SEL_W  channel index used when mode = 0
- valid_in  input  N_CH  per-channel data valid
- data_in  input  N_CH*DATA_W  flattened; channel c at [c*DATA_W +: DATA_W]
- ready_in  output  N_CH  per-channel pop/accept, combinational
- ready_out  input  1  downstream ready
- valid_out  output  1  registered output valid
- data_out  output  DATA_W  registered output data
- sel_out  output  SEL_W  channel that produced current data_out

## Operation
- Output slot free: free = !valid_out || ready_out.
- Grant (one-hot, combinational):
  - mode 0: grant[selector] if selector < N_CH and valid_in[selector]; selector >= N_CH grants nothing.
  - mode 1: first c with valid_in[c], searching cyclically from ptr (ptr, ptr+1, ..., N_CH-1, 0, ...). No valid input: no grant.
- ready_in[c] = reset_L && free && grant[c]; at most one bit high.
- Transfer when any ready_in[c] && valid_in[c] (channel g):
  - valid_out <= 1, data_out <= data_in[g], sel_out <= g.
  - mode 1 only: ptr <= (g == N_CH-1) ? 0 : g+1.
- No transfer and ready_out = 1: valid_out <= 0; data_out, sel_out hold last value.
- No transfer and ready_out = 0: all outputs hold (stall).
- ptr changes only on a mode-1 transfer; preserved across mode switches.
- mode and selector sampled every cycle; changes take effect on next grant computation.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): valid_out = 0, data_out = 0, sel_out = 0, ptr = 0, ready_in = 0 while reset_L = 0.
- Latency: accept on edge k -> valid_out/data_out valid after edge k.
- Throughput: one word per cycle while ready_out = 1 and a granted channel is valid.
- Simultaneous ready_out = 1 and new transfer: old word consumed, new word loaded same edge, valid_out stays 1.
- Reset mid-stall: output word discarded; no ready_in pulse issued for it.
- ready_in combinational from ready_out, valid_in, mode, selector, ptr; no path from ready_in to valid_in inside block.

## Configuration
- MUX_NA1_CNT_EN defined: adds output xfer_count (16 bits), increments on every transfer, saturates at 16'hFFFF, cleared by reset_L.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package mux_pkg: MODE_EXT = 1'b0, MODE_RR = 1'b1, default DATA_W, counter width 16.
- One sub-module rr_arbiter (N_CH, inputs req, ptr; output one-hot gnt and encoded index), used for mode 1.
- Top holds selector decode, output register, ptr register, optional counter.

## Test plan
All with N_CH = 4, DATA_W = 8.
- Reset: reset_L = 0 during activity -> valid_out = 0, data_out = 8'h00, sel_out = 0, ready_in = 4'b0000 immediately.
- Mode 0, selector = 2, valid_in = 4'b0100, data ch2 = 8'hA5, ready_out = 1 -> ready_in = 4'b0100; next cycle valid_out = 1, data_out = 8'hA5, sel_out = 2.
- Mode 1, all valid, data ch c = 8'h10+c, ready_out = 1 for 8 cycles -> data_out sequence 10,11,12,13,10,11,12,13.
- Mode 1, ptr = 1, valid_in = 4'b1001 -> ch3 granted first, then ch0; ch1/ch2 never granted.
- Backpressure: word 8'h3C held, ready_out = 0 for 3 cycles -> ready_in = 0, data_out = 8'h3C, valid_out = 1; ready_out = 1 with no valid_in -> valid_out = 0, data_out still 8'h3C.
- MUX_NA1_CNT_EN: 70000 back-to-back transfers -> xfer_count = 16'hFFFF, no wrap.
